// File: rtl/mem_loader_if.sv
// Host stream and memory port bundle for mem_loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface mem_loader_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [AW-1:0] mem_dpra;
    logic [DW-1:0] mem_dpo;

    modport master (
        input  in_valid, in_data, mem_dpo,
        output in_ready, mem_a, mem_d, mem_we, mem_dpra
    );

    modport slave (
        output in_valid, in_data, mem_dpo,
        input  in_ready, mem_a, mem_d, mem_we, mem_dpra
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: streams host words into a 1K x 32 memory from a programmable base while holding the CPU in reset.
// Define LOADER_VERIFY_EN to read back and compare every word (adds the CHECK state and the sticky error flag).
module mem_loader #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int LW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    mem_loader_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [LW-1:0] words_loaded,
    output logic          cpu_hold
);
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << AW;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] rem_q;
    logic [LW-1:0] cnt_q;
    logic          in_ready_c;
    logic          accept;
    logic          load_go;
    logic          advance;
`ifdef LOADER_VERIFY_EN
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic          set_err;
`endif

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_go    = 1'b0;
        advance    = 1'b0;
`ifdef LOADER_VERIFY_EN
        set_err    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_go = 1'b1;
                    state_d = (clamp_len(length) == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
`ifdef LOADER_VERIFY_EN
                    state_d = S_CHECK;
`else
                    advance = 1'b1;
                    if (rem_q == LW'(1)) state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            // The word written last edge is now visible on mem_dpo at addr_q.
            S_CHECK: begin
                busy = 1'b1;
                if (bus.mem_dpo == wdata_q) begin
                    advance = 1'b1;
                    state_d = (rem_q == LW'(1)) ? S_DONE : S_LOAD;
                end else begin
                    set_err = 1'b1;
                    state_d = S_ERROR;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign accept       = in_ready_c & bus.in_valid;
    assign bus.in_ready = in_ready_c;
    assign bus.mem_we   = accept;
    assign bus.mem_a    = addr_q;
    assign bus.mem_d    = bus.in_data;
    assign bus.mem_dpra = addr_q;
    assign cpu_hold     = busy;
    assign words_loaded = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Address wraps modulo 2^AW, so a load running past the top continues at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (load_go) begin
            addr_q <= base_addr;
            rem_q  <= clamp_len(length);
            cnt_q  <= '0;
        end else if (advance) begin
            addr_q <= addr_q + AW'(1);
            rem_q  <= rem_q - LW'(1);
            cnt_q  <= cnt_q + LW'(1);
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (load_go) err_q <= 1'b0;
        else if (set_err) err_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) wdata_q <= bus.in_data;
    end

    assign error = err_q;
`else
    logic unused_dpo;
    assign unused_dpo = ^bus.mem_dpo;
    assign error      = 1'b0;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with a behavioural 1K x 32 memory model.
module tb_mem_loader;
`ifdef LOADER_VERIFY_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done, error, cpu_hold;
    logic [10:0] words_loaded;

    mem_loader_if #(.AW(10), .DW(32)) bus ();

    mem_loader #(.AW(10), .DW(32), .LW(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .cpu_hold     (cpu_hold)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic        corrupt_en = 1'b0;
    logic [9:0]  corrupt_addr = '0;
    assign bus.mem_dpo = (corrupt_en && bus.mem_dpra == corrupt_addr) ? 32'hDEADBEEF : mem[bus.mem_dpra];

    int cyc_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int hold_bad = 0;
    int we_bad = 0;
    logic [9:0]  wr_a [4096];
    logic [31:0] wr_d [4096];
    int          wr_cyc [4096];

    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_d;
            wr_a[wr_cnt]   = bus.mem_a;
            wr_d[wr_cnt]   = bus.mem_d;
            wr_cyc[wr_cnt] = cyc_cnt;
            wr_cnt = wr_cnt + 1;
            if (!bus.in_valid) we_bad = we_bad + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc_cnt;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (cpu_hold !== busy) hold_bad = hold_bad + 1;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds words dbase+i until done or error shows up, or the cycle budget runs out.
    task automatic run_load(input string tag, input int nw, input logic [31:0] dbase,
                            input bit toggle, input int budget);
        int idx = 0;
        int cyc = 0;
        int d0 = done_cnt;
        bit stop = 0;
        while (!stop) begin
            @(negedge clk);
            bus.in_data  = dbase + idx;
            bus.in_valid = (idx < nw) && (!toggle || (cyc % 2 == 0));
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
            if (done_cnt != d0 || error || cyc >= budget) stop = 1;
        end
        bus.in_valid = 1'b0;
        check({tag, "_finished"}, 32'((done_cnt != d0) || error), 32'd1);
    endtask

    int w0, d0, b0, idx, cyc;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset with in_valid asserted
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_mem_we",   32'(bus.mem_we), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_error",    32'(error), 0);
        check("rst_words",    32'(words_loaded), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rel_busy", 32'(busy), 0);
        check("rst_rel_we",   32'(bus.mem_we), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_rel_wr", wr_cnt, 0);

        // Basic load of 4 words at 0x010
        w0 = wr_cnt; d0 = done_cnt;
        do_start(10'h010, 11'd4);
        run_load("basic", 4, 32'hA0, 1'b0, 40);
        repeat (2) @(negedge clk);
        check("basic_nwr", wr_cnt - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_addr%0d", i), 32'(wr_a[w0 + i]), 32'h10 + i);
            check($sformatf("basic_data%0d", i), wr_d[w0 + i], 32'hA0 + i);
        end
        check("basic_span", wr_cyc[w0 + 3] - wr_cyc[w0], 3 * STEP);
        check("basic_done_lat", done_cyc - wr_cyc[w0 + 3], STEP);
        check("basic_done_once", done_cnt - d0, 1);
        check("basic_words", 32'(words_loaded), 4);
        check("basic_mem13", mem[10'h013], 32'hA3);
        check("basic_busy_end", 32'(busy), 0);

        // Backpressure with address wrap
        w0 = wr_cnt; d0 = done_cnt;
        do_start(10'h3FE, 11'd4);
        run_load("wrap", 4, 32'hB0, 1'b1, 60);
        repeat (2) @(negedge clk);
        check("wrap_nwr", wr_cnt - w0, 4);
        check("wrap_a0", 32'(wr_a[w0]),     32'h3FE);
        check("wrap_a1", 32'(wr_a[w0 + 1]), 32'h3FF);
        check("wrap_a2", 32'(wr_a[w0 + 2]), 32'h000);
        check("wrap_a3", 32'(wr_a[w0 + 3]), 32'h001);
        check("wrap_mem0", mem[10'h000], 32'hB2);
        check("wrap_done_once", done_cnt - d0, 1);
        check("wrap_no_idle_we", we_bad, 0);

        // Zero length completes with no write and no busy
        w0 = wr_cnt; b0 = busy_cnt;
        do_start(10'h100, 11'd0);
        #1;
        check("len0_done", 32'(done), 1);
        check("len0_busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        check("len0_done_off", 32'(done), 0);
        check("len0_nwr", wr_cnt - w0, 0);
        check("len0_busy_seen", busy_cnt - b0, 0);

        // Oversized length clamps to the full memory
        w0 = wr_cnt; d0 = done_cnt;
        do_start(10'h123, 11'd2000);
        run_load("clamp", 1100, 32'h1000, 1'b0, 3000);
        repeat (2) @(negedge clk);
        check("clamp_nwr", wr_cnt - w0, 1024);
        check("clamp_words", 32'(words_loaded), 1024);
        check("clamp_done_once", done_cnt - d0, 1);
        check("clamp_first", mem[10'h123], 32'h1000);
        check("clamp_last", mem[10'h122], 32'h1000 + 1023);

        // Start ignored mid-load, then async reset aborts
        do_start(10'h200, 11'd5);
        w0 = wr_cnt; d0 = done_cnt; idx = 0; cyc = 0;
        while (idx < 2 && cyc < 20) begin
            @(negedge clk);
            start = (cyc == 0); base_addr = 10'h300; length = 11'd1;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC0 + idx;
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        start = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("abort_nwr", wr_cnt - w0, 2);
        check("abort_a0", 32'(wr_a[w0]),     32'h200);
        check("abort_a1", 32'(wr_a[w0 + 1]), 32'h201);
        check("abort_words_pre", 32'(words_loaded), 2);
        check("abort_busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_hold", 32'(cpu_hold), 0);
        check("abort_ready", 32'(bus.in_ready), 0);
        check("abort_words", 32'(words_loaded), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_mem_kept", mem[10'h201], 32'hC1);

        d0 = done_cnt;
        do_start(10'h050, 11'd1);
        run_load("fresh", 1, 32'hD0, 1'b0, 20);
        @(negedge clk);
        check("fresh_done_once", done_cnt - d0, 1);
        check("fresh_mem", mem[10'h050], 32'hD0);
        check("fresh_words", 32'(words_loaded), 1);

`ifdef LOADER_VERIFY_EN
        // Read-back mismatch on the third word
        corrupt_addr = 10'h082; corrupt_en = 1'b1; d0 = done_cnt;
        do_start(10'h080, 11'd5);
        run_load("vfy", 5, 32'hE0, 1'b0, 40);
        check("vfy_err", 32'(error), 1);
        check("vfy_words", 32'(words_loaded), 2);
        repeat (3) @(negedge clk);
        #1;
        check("vfy_err_sticky", 32'(error), 1);
        check("vfy_busy", 32'(busy), 0);
        check("vfy_no_done", done_cnt - d0, 0);
        corrupt_en = 1'b0;
        do_start(10'h090, 11'd1);
        #1;
        check("vfy_err_clr", 32'(error), 0);
        run_load("vfy_next", 1, 32'hF0, 1'b0, 20);
        @(negedge clk);
        check("vfy_next_done", done_cnt - d0, 1);
`endif

        check("hold_tracks_busy", hold_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
